// File: rtl/page_table_responder.sv
// ============================================================================
// page_table_responder
// ----------------------------------------------------------------------------
// Page-table side of the TLB <-> PageTable interface. It answers TLB refill
// reads and absorbs dirty write-backs from the TLB. It holds the VPN->PPN map
// for a small paged system (default: 6-bit VPN, 2-bit PPN).
//
// On a read of an unmapped VPN, the block raises a page fault. It then
// allocates a physical frame round-robin and evicts that frame's previous
// owner. Every request ends with a one-cycle done pulse.
//
// Storage
//   pt[vpn]      = {valid, dirty, ppn}  forward map, one entry per VPN
//   owner[frame] = {valid, vpn}         reverse map, one entry per frame
//   victim                              next frame handed out on a fault
//
// The forward and reverse maps are kept consistent. A frame has at most one
// owning VPN, and a VPN maps to at most one frame.
//
// Ports
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   req_valid      in   1      request strobe, sampled only while req_ready=1
//   req_ready      out  1      idle and able to accept a request
//   write_to_table in   1      1 = write-back of (VPN, PPN), 0 = read
//   V_addr_TLB_in  in   VPN_W  VPN of the request
//   P_addr_TLB_in  in   PPN_W  PPN to store (writes only)
//   done           out  1      one-cycle completion pulse
//   P_addr_TLB_out out  PPN_W  PPN returned by a read, held until next done
//   page_fault     out  1      high with done when the read allocated a frame
//   fault_count    out  8      saturating count of page faults since reset
// ============================================================================
module page_table_responder #(
    parameter int VPN_W      = 6,
    parameter int PPN_W      = 2,
    parameter int LOOKUP_LAT = 2,
    parameter int FAULT_LAT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             write_to_table,
    input  logic [VPN_W-1:0] V_addr_TLB_in,
    input  logic [PPN_W-1:0] P_addr_TLB_in,
    output logic             done,
    output logic [PPN_W-1:0] P_addr_TLB_out,
    output logic             page_fault,
    output logic [7:0]       fault_count
);

    localparam int DEPTH   = 1 << VPN_W;
    localparam int FRAMES  = 1 << PPN_W;
    localparam int LAT_MAX = (LOOKUP_LAT > FAULT_LAT) ? LOOKUP_LAT : FAULT_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOOKUP_LOAD = CNT_W'(LOOKUP_LAT - 1);
    localparam logic [CNT_W-1:0] FAULT_LOAD  = CNT_W'(FAULT_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FAULT,
        RESP
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               req_write;
    logic [VPN_W-1:0]   req_vpn;
    logic [PPN_W-1:0]   req_ppn;

    // Valid bits must be cleared by reset; the payload fields need not be.
    logic [DEPTH-1:0]   pt_valid;
    logic [DEPTH-1:0]   pt_dirty;
    logic [PPN_W-1:0]   pt_ppn    [DEPTH];
    logic [FRAMES-1:0]  owner_valid;
    logic [VPN_W-1:0]   owner_vpn [FRAMES];
    logic [PPN_W-1:0]   victim;

    // ------------------------------------------------------------------------
    // Decode of the latched request against the current table contents
    // ------------------------------------------------------------------------
    logic               lookup_exit;   // last LOOKUP cycle
    logic               fault_exit;    // last FAULT cycle
    logic               tbl_write_en;  // write-back commits this cycle
    logic               tbl_alloc_en;  // fault allocation commits this cycle
    logic               cur_hit;       // requested VPN is mapped
    logic [PPN_W-1:0]   cur_ppn;       // its current frame, when mapped
    logic               wr_steal;      // target frame owned by another VPN
    logic [VPN_W-1:0]   wr_prev_vpn;   // that other VPN
    logic               wr_moved;      // VPN is leaving a different frame
    logic               evict_valid;   // victim frame currently has an owner
    logic [VPN_W-1:0]   evict_vpn;     // that owner

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        lookup_exit  = 1'b0;
        fault_exit   = 1'b0;
        tbl_write_en = 1'b0;
        tbl_alloc_en = 1'b0;
        cur_hit      = pt_valid[req_vpn];
        cur_ppn      = pt_ppn[req_vpn];
        wr_prev_vpn  = owner_vpn[req_ppn];
        wr_steal     = 1'b0;
        wr_moved     = 1'b0;
        evict_valid  = owner_valid[victim];
        evict_vpn    = owner_vpn[victim];

        if (state == LOOKUP && cnt == '0) begin
            lookup_exit = 1'b1;
        end
        if (state == FAULT && cnt == '0) begin
            fault_exit = 1'b1;
        end

        tbl_write_en = lookup_exit && req_write;
        tbl_alloc_en = fault_exit;

        // One frame, one owner: a write onto a frame held by another VPN
        // unmaps that VPN. A VPN moving to a new frame releases its old one.
        wr_steal = owner_valid[req_ppn] && (wr_prev_vpn != req_vpn);
        wr_moved = cur_hit && (cur_ppn != req_ppn);
    end

    // ------------------------------------------------------------------------
    // Table payload (ppn, dirty, reverse-map vpn)
    // ------------------------------------------------------------------------
    // NOTE: the payload arrays are deliberately left out of reset. Each entry
    // is qualified by a valid bit that is reset, so a stale payload is never
    // observed, and the arrays can map onto plain storage.
    always_ff @(posedge clk) begin
        if (tbl_write_en) begin
            pt_ppn[req_vpn]    <= req_ppn;
            pt_dirty[req_vpn]  <= 1'b1;
            owner_vpn[req_ppn] <= req_vpn;
        end
        if (tbl_alloc_en) begin
            pt_ppn[req_vpn]    <= victim;
            pt_dirty[req_vpn]  <= 1'b0;
            owner_vpn[victim]  <= req_vpn;
        end
    end

    // The dirty bit is recorded for a future eviction write-back path.
    // Nothing consumes it yet.
    logic unused_dirty;
    assign unused_dirty = ^pt_dirty;

    // ------------------------------------------------------------------------
    // Control FSM, valid bits, victim pointer and registered outputs
    // ------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, so table reads in the decode above
    // never see a same-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            req_write      <= 1'b0;
            req_vpn        <= '0;
            req_ppn        <= '0;
            pt_valid       <= '0;
            owner_valid    <= '0;
            victim         <= '0;
            req_ready      <= 1'b1;
            done           <= 1'b0;
            page_fault     <= 1'b0;
            P_addr_TLB_out <= '0;
            fault_count    <= '0;
        end else begin
            // done and page_fault are single-cycle pulses, raised only on
            // the edge that enters RESP.
            done       <= 1'b0;
            page_fault <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_write <= write_to_table;
                        req_vpn   <= V_addr_TLB_in;
                        req_ppn   <= P_addr_TLB_in;
                        cnt       <= LOOKUP_LOAD;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (!lookup_exit) begin
                        cnt <= cnt - 1'b1;
                    end else if (req_write) begin
                        if (wr_steal) begin
                            pt_valid[wr_prev_vpn] <= 1'b0;
                        end
                        if (wr_moved) begin
                            owner_valid[cur_ppn] <= 1'b0;
                        end
                        pt_valid[req_vpn]    <= 1'b1;
                        owner_valid[req_ppn] <= 1'b1;
                        done                 <= 1'b1;
                        state                <= RESP;
                    end else if (cur_hit) begin
                        P_addr_TLB_out <= cur_ppn;
                        done           <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt   <= FAULT_LOAD;
                        state <= FAULT;
                    end
                end

                FAULT: begin
                    if (!fault_exit) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // The evicted owner is always a different VPN,
                        // because the faulting VPN was unmapped.
                        if (evict_valid) begin
                            pt_valid[evict_vpn] <= 1'b0;
                        end
                        pt_valid[req_vpn]   <= 1'b1;
                        owner_valid[victim] <= 1'b1;
                        victim              <= victim + 1'b1;
                        if (fault_count != 8'hFF) begin
                            fault_count <= fault_count + 8'd1;
                        end
                        P_addr_TLB_out <= victim;
                        page_fault     <= 1'b1;
                        done           <= 1'b1;
                        state          <= RESP;
                    end
                end

                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
